// File: rtl/algo_nror1w_wrsched.sv
// Write-port scheduler for the duplicated nR1W algo top.
// After reset it sweeps every address with INITVAL. Once the sweep completes,
// it shares the single write port among NUMWRRQ requesters in round-robin order.
// Reads are blocked until the sweep has finished.
module algo_nror1w_wrsched #(
    parameter int WIDTH   = 32,
    parameter int NUMADDR = 8192,
    parameter int BITADDR = 13,
    parameter int NUMRDPT = 4,
    parameter int NUMWRRQ = 3,
    parameter int BITWRRQ = 2,
    parameter logic [WIDTH-1:0] INITVAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reinit,
    input  logic [NUMWRRQ-1:0]         rq_vld,
    input  logic [NUMWRRQ*BITADDR-1:0] rq_adr,
    input  logic [NUMWRRQ*WIDTH-1:0]   rq_bw,
    input  logic [NUMWRRQ*WIDTH-1:0]   rq_din,
    output logic [NUMWRRQ-1:0]         rq_rdy,
    input  logic [NUMRDPT-1:0]         rd_in,
    output logic [NUMRDPT-1:0]         read,
    output logic [NUMRDPT-1:0]         rd_blk,
    output logic                       write,
    output logic [BITADDR-1:0]         wr_adr,
    output logic [WIDTH-1:0]           bw,
    output logic [WIDTH-1:0]           din,
    output logic                       init_done
);

    localparam logic [0:0]         INIT    = 1'b0;
    localparam logic [0:0]         RUN     = 1'b1;
    localparam logic [BITADDR-1:0] LASTADR = BITADDR'(NUMADDR - 1);
    localparam logic [BITWRRQ-1:0] LASTRQ  = BITWRRQ'(NUMWRRQ - 1);
    localparam logic [BITWRRQ:0]   NUMRQW  = (BITWRRQ + 1)'(NUMWRRQ);

    logic [0:0]         state;
    logic [BITADDR-1:0] cnt;
    logic [BITWRRQ-1:0] rrPtr;

    logic [NUMWRRQ-1:0] grant;
    logic [BITWRRQ-1:0] grantIdx;
    logic               anyGrant;
    logic [BITWRRQ:0]   probe;
    logic [BITWRRQ-1:0] probeIdx;
    logic [BITWRRQ-1:0] nextPtr;

    logic [BITADDR-1:0] selAdr;
    logic [WIDTH-1:0]   selBw;
    logic [WIDTH-1:0]   selDin;

    logic runActive;
    assign runActive = !rst && (state == RUN);

    // Round-robin search starting at rrPtr; reinit suppresses any grant that cycle
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        probe    = '0;
        probeIdx = '0;
        if (runActive && !reinit) begin
            for (int k = 0; k < NUMWRRQ; k++) begin
                probe = {1'b0, rrPtr} + (BITWRRQ + 1)'(k);
                if (probe >= NUMRQW) begin
                    probe = probe - NUMRQW;
                end
                probeIdx = probe[BITWRRQ-1:0];
                if (!anyGrant && rq_vld[probeIdx]) begin
                    anyGrant = 1'b1;
                    grantIdx = probeIdx;
                end
            end
            if (anyGrant) begin
                grant[grantIdx] = 1'b1;
            end
        end
    end

    // Pointer moves to the requester just after the one granted
    always_comb begin
        nextPtr = grantIdx + BITWRRQ'(1);
        if (grantIdx == LASTRQ) begin
            nextPtr = '0;
        end
    end

    // Pick the payload of the granted requester
    always_comb begin
        selAdr = '0;
        selBw  = '0;
        selDin = '0;
        for (int i = 0; i < NUMWRRQ; i++) begin
            if (grant[i]) begin
                selAdr = rq_adr[i*BITADDR +: BITADDR];
                selBw  = rq_bw[i*WIDTH +: WIDTH];
                selDin = rq_din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rq_rdy = grant;
    assign read   = runActive ? rd_in : '0;
    assign rd_blk = (!rst && (state == INIT)) ? rd_in : '0;

    // Init sweep, then arbitrated writes; reinit sends RUN back to a fresh sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            rrPtr     <= '0;
            write     <= 1'b0;
            wr_adr    <= '0;
            bw        <= '0;
            din       <= '0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            write     <= 1'b1;
            wr_adr    <= cnt;
            bw        <= '1;
            din       <= INITVAL;
            init_done <= 1'b0;
            if (cnt == LASTADR) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + BITADDR'(1);
            end
        end else begin
            init_done <= !reinit;
            if (reinit) begin
                state <= INIT;
                cnt   <= '0;
                write <= 1'b0;
            end else if (anyGrant) begin
                write  <= 1'b1;
                wr_adr <= selAdr;
                bw     <= selBw;
                din    <= selDin;
                rrPtr  <= nextPtr;
            end else begin
                write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_algo_nror1w_wrsched.sv
// Testbench for algo_nror1w_wrsched with a small address space.
// A behavioural model predicts every output each cycle. A scoreboard
// confirms that each accepted request is written once, in grant order.
module tb_algo_nror1w_wrsched;

    localparam int WIDTH   = 8;
    localparam int NUMADDR = 16;
    localparam int BITADDR = 4;
    localparam int NUMRDPT = 4;
    localparam int NUMWRRQ = 3;
    localparam int BITWRRQ = 2;
    localparam logic [7:0] INITVAL = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        reinit;
    logic [2:0]  rq_vld;
    logic [11:0] rq_adr;
    logic [23:0] rq_bw;
    logic [23:0] rq_din;
    logic [2:0]  rq_rdy;
    logic [3:0]  rd_in;
    logic [3:0]  read;
    logic [3:0]  rd_blk;
    logic        write;
    logic [3:0]  wr_adr;
    logic [7:0]  bw;
    logic [7:0]  din;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit         mRun  = 1'b0;
    int         mCnt  = 0;
    int         mPtr  = 0;
    logic       mWrite = 1'b0;
    logic [3:0] mAdr  = '0;
    logic [7:0] mBw   = '0;
    logic [7:0] mDin  = '0;
    logic       mDone = 1'b0;

    // observations captured in the combinational phase of the latest cycle
    logic [2:0] lastRdy;
    logic [2:0] lastVld;
    logic [3:0] lastRead;
    logic [3:0] lastBlk;

    // scoreboard
    bit          sbActive = 1'b0;
    logic [19:0] expQ[$];
    int          waits[3];

    algo_nror1w_wrsched #(
        .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMRDPT(NUMRDPT),
        .NUMWRRQ(NUMWRRQ), .BITWRRQ(BITWRRQ), .INITVAL(INITVAL)
    ) dut (
        .clk(clk), .rst(rst), .reinit(reinit),
        .rq_vld(rq_vld), .rq_adr(rq_adr), .rq_bw(rq_bw), .rq_din(rq_din),
        .rq_rdy(rq_rdy), .rd_in(rd_in), .read(read), .rd_blk(rd_blk),
        .write(write), .wr_adr(wr_adr), .bw(bw), .din(din), .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // first requester at or after the pointer, wrapping around
    function automatic int pick(input logic [2:0] vld, input int ptr);
        for (int k = 0; k < NUMWRRQ; k++) begin
            if (vld[(ptr + k) % NUMWRRQ]) return (ptr + k) % NUMWRRQ;
        end
        return -1;
    endfunction

    task automatic cycle();
        int         g;
        int         gd;
        logic [2:0] eRdy;
        logic [3:0] eRead;
        logic [3:0] eBlk;
        #3;
        g = -1; eRdy = '0; eRead = '0; eBlk = '0;
        if (!rst) begin
            if (!mRun) begin
                eBlk = rd_in;
            end else begin
                eRead = rd_in;
                if (!reinit) begin
                    g = pick(rq_vld, mPtr);
                    if (g >= 0) eRdy[g] = 1'b1;
                end
            end
        end
        chk("rq_rdy", 32'(rq_rdy), 32'(eRdy));
        chk("read", 32'(read), 32'(eRead));
        chk("rd_blk", 32'(rd_blk), 32'(eBlk));
        lastRdy = rq_rdy; lastVld = rq_vld; lastRead = read; lastBlk = rd_blk;
        if (sbActive) begin
            gd = -1;
            for (int j = 0; j < NUMWRRQ; j++) begin
                if (rq_vld[j] && rq_rdy[j]) gd = j;
            end
            if (gd >= 0) begin
                expQ.push_back({rq_adr[gd*4 +: 4], rq_bw[gd*8 +: 8], rq_din[gd*8 +: 8]});
                for (int i = 0; i < NUMWRRQ; i++) begin
                    if (i == gd) begin
                        checks++;
                        assert (waits[i] <= NUMWRRQ - 1) else begin
                            failures++;
                            $error("[TB] FAIL fair_wait req%0d observed=%0d expected<=%0d", i, waits[i], NUMWRRQ - 1);
                        end
                        waits[i] = 0;
                    end else if (rq_vld[i]) begin
                        waits[i]++;
                    end
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            mRun = 1'b0; mCnt = 0; mPtr = 0;
            mWrite = 1'b0; mAdr = '0; mBw = '0; mDin = '0; mDone = 1'b0;
        end else if (!mRun) begin
            mWrite = 1'b1; mAdr = 4'(mCnt); mBw = 8'hFF; mDin = INITVAL; mDone = 1'b0;
            if (mCnt == NUMADDR - 1) begin
                mRun = 1'b1; mCnt = 0;
            end else begin
                mCnt++;
            end
        end else begin
            mDone = !reinit;
            if (reinit) begin
                mRun = 1'b0; mCnt = 0; mWrite = 1'b0;
            end else if (g >= 0) begin
                mWrite = 1'b1;
                mAdr = rq_adr[g*4 +: 4];
                mBw  = rq_bw[g*8 +: 8];
                mDin = rq_din[g*8 +: 8];
                mPtr = (g + 1) % NUMWRRQ;
            end else begin
                mWrite = 1'b0;
            end
        end
        #1;
        chk("write", 32'(write), 32'(mWrite));
        chk("wr_adr", 32'(wr_adr), 32'(mAdr));
        chk("bw", 32'(bw), 32'(mBw));
        chk("din", 32'(din), 32'(mDin));
        chk("init_done", 32'(init_done), 32'(mDone));
        if (sbActive && write) begin
            checks++;
            assert (expQ.size() > 0) else begin
                failures++;
                $error("[TB] FAIL sb_extra_write observed=write expected=no_write");
            end
            if (expQ.size() > 0) begin
                chk("sb_payload", 32'({wr_adr, bw, din}), 32'(expQ.pop_front()));
            end
        end
    endtask

    task automatic newPayload(input int i);
        rq_adr[i*4 +: 4] = 4'($urandom);
        rq_bw[i*8 +: 8]  = 8'($urandom);
        rq_din[i*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; reinit = 1'b0; rq_vld = '0; rq_adr = '0; rq_bw = '0; rq_din = '0; rd_in = 4'hF;
        for (int i = 0; i < NUMWRRQ; i++) waits[i] = 0;

        // reset state
        cycle();
        cycle();
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_read", 32'(lastRead), 32'd0);
        chk("rst_blk", 32'(lastBlk), 32'd0);

        // init sweep with every requester asking, reads blocked
        rst = 1'b0; rq_vld = 3'b111;
        for (int i = 0; i < NUMWRRQ; i++) newPayload(i);
        for (int k = 0; k < NUMADDR; k++) begin
            cycle();
            chk("t1_adr", 32'(wr_adr), 32'(k));
            chk("t1_rdy", 32'(lastRdy), 32'd0);
            chk("t2_blk", 32'(lastBlk), 32'hF);
        end
        chk("t1_done_late", 32'(init_done), 32'd0);
        cycle();
        chk("t1_done", 32'(init_done), 32'd1);
        chk("t1_g0", 32'(lastRdy), 32'b001);
        chk("t2_read", 32'(lastRead), 32'hF);
        chk("t2_blk_run", 32'(lastBlk), 32'd0);
        chk("t1_g0_adr", 32'(wr_adr), 32'(rq_adr[3:0]));
        cycle();
        chk("t1_g1", 32'(lastRdy), 32'b010);
        cycle();
        chk("t1_g2", 32'(lastRdy), 32'b100);
        cycle();
        chk("t1_g0b", 32'(lastRdy), 32'b001);

        // pointer at 1, requesters 0 and 2 asking
        rq_vld = 3'b101;
        cycle();
        chk("t3_rdy", 32'(lastRdy), 32'b100);
        chk("t3_din", 32'(din), 32'(rq_din[23:16]));
        cycle();
        chk("t3_rdy2", 32'(lastRdy), 32'b001);

        // reinit in RUN beats a pending request
        rq_vld = 3'b010; reinit = 1'b1;
        cycle();
        chk("t4_rdy", 32'(lastRdy), 32'd0);
        chk("t4_nowrite", 32'(write), 32'd0);
        reinit = 1'b0;
        cycle();
        chk("t4_adr0", 32'(wr_adr), 32'd0);
        chk("t4_din0", 32'(din), 32'(INITVAL));
        chk("t4_done0", 32'(init_done), 32'd0);
        reinit = 1'b1;
        cycle();
        chk("t4_reinit_ignored", 32'(wr_adr), 32'd1);
        reinit = 1'b0;
        for (int k = 2; k < NUMADDR; k++) cycle();
        cycle();
        chk("t4_req1_first", 32'(lastRdy), 32'b010);

        // reset in the middle of a sweep
        rq_vld = '0; reinit = 1'b1;
        cycle();
        reinit = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        chk("t5_adr7", 32'(wr_adr), 32'd7);
        rst = 1'b1;
        cycle();
        chk("t5_write", 32'(write), 32'd0);
        chk("t5_adr", 32'(wr_adr), 32'd0);
        chk("t5_bw", 32'(bw), 32'd0);
        chk("t5_read", 32'(lastRead), 32'd0);
        chk("t5_blk", 32'(lastBlk), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < NUMADDR; k++) begin
            cycle();
            chk("t5_sweep", 32'(wr_adr), 32'(k));
        end
        cycle();

        // random traffic with scoreboard and fairness checks
        sbActive = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NUMWRRQ; i++) begin
                if (!rq_vld[i] && $urandom_range(0, 99) < 50) begin
                    rq_vld[i] = 1'b1;
                    newPayload(i);
                end
            end
            rd_in = 4'($urandom);
            cycle();
            for (int i = 0; i < NUMWRRQ; i++) begin
                if (lastVld[i] && lastRdy[i]) rq_vld[i] = 1'b0;
            end
        end
        rq_vld = '0;
        cycle();
        cycle();
        chk("sb_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
